tt_um_vga_rx: RTL and testbench

TT_UM_VGA_RX -- requirements
Module: tt_um_vga_rx

---
 rtl/vga_rx_pkg.sv | 43 ++++
 rtl/vga_rx_if.sv | 8 +
 rtl/vga_rx_sync.sv | 33 +++
 rtl/tt_um_vga_rx.sv | 217 +++++++++++++++++++++
 tb/tb_tt_um_vga_rx.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/vga_rx_pkg.sv
// TinyVGA receiver shared definitions.
// Widths, FSM states, readout selects and the CRC-8 step.
package vga_rx_pkg;

    localparam int PERIOD_W     = 10;
    localparam int LINES_W      = 10;
    localparam int FRAME_W      = 8;
    localparam int LOCK_MATCHES = 3;
    localparam logic [7:0] CRC_POLY = 8'h07;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_STATUS = 3'd0,
        SEL_PER_LO = 3'd1,
        SEL_PER_HI = 3'd2,
        SEL_LPF_LO = 3'd3,
        SEL_LPF_HI = 3'd4,
        SEL_FRAMES = 3'd5,
        SEL_CRC    = 3'd6,
        SEL_ZERO   = 3'd7
    } sel_e;

    // Six data bits shifted in MSB first.
    function automatic logic [7:0] crc8_step6(
        input logic [7:0] crc,
        input logic [5:0] d
    );
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 5; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_rx_if.sv
// Synchronised level plus falling-edge event for one sync pin.
interface vga_rx_if;
    logic s;
    logic fall;

    modport master (output s, output fall);
    modport slave  (input s, input fall);
endinterface

// File: rtl/vga_rx_sync.sv
// Two-flop synchroniser with a registered falling-edge detector.
module vga_rx_sync
    import vga_rx_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_pin,
    vga_rx_if.master o_ev
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_fall <= r_prev & ~r_sync;
        end
    end

    assign o_ev.s    = r_sync;
    assign o_ev.fall = r_fall;

endmodule

// File: rtl/tt_um_vga_rx.sv
// TinyVGA timing receiver: line period, lines per frame, lock FSM.
// Optional frame CRC enabled by defining VGA_RX_CRC_EN.
module tt_um_vga_rx
    import vga_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] MATCH_LAST = 2'(LOCK_MATCHES - 1);

    vga_rx_if h_ev ();
    vga_rx_if v_ev ();

    vga_rx_sync u_hsync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_pin (ui_in[7]),
        .o_ev  (h_ev)
    );

    vga_rx_sync u_vsync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_pin (ui_in[3]),
        .o_ev  (v_ev)
    );

    // Colour order {R1,R0,G1,G0,B1,B0}
    logic [5:0] r_col_meta;
    logic [5:0] r_col;
    logic [5:0] w_col_pin;

    assign w_col_pin = {ui_in[0], ui_in[4], ui_in[1],
                        ui_in[5], ui_in[2], ui_in[6]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_meta <= '0;
            r_col      <= '0;
        end else begin
            r_col_meta <= w_col_pin;
            r_col      <= r_col_meta;
        end
    end

    logic w_hev;
    logic w_vev;
    logic w_sat;
    logic w_locked;

    assign w_hev    = h_ev.fall;
    assign w_vev    = v_ev.fall;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [PERIOD_W-1:0]   r_cnt;
    logic [PERIOD_W-1:0]   r_period;
    logic [PERIOD_W-1:0]   r_ref;
    logic [PERIOD_W-1:0]   w_ref_nxt;
    logic [1:0]            r_match;
    logic [1:0]            w_match_nxt;

    assign w_sat    = &r_cnt;
    assign w_locked = (r_state == ST_LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SEARCH;
            r_ref   <= '0;
            r_match <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ref   <= w_ref_nxt;
            r_match <= w_match_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ref_nxt   = r_ref;
        w_match_nxt = r_match;
        if (w_sat && r_state != ST_SEARCH) begin
            w_state_nxt = ST_SEARCH;
            w_match_nxt = '0;
        end else if (w_hev) begin
            unique case (r_state)
                ST_SEARCH: w_state_nxt = ST_MEASURE;
                ST_MEASURE: begin
                    if (r_cnt == r_ref) begin
                        w_match_nxt = r_match + 2'd1;
                        if (r_match == MATCH_LAST)
                            w_state_nxt = ST_LOCKED;
                    end else begin
                        w_ref_nxt   = r_cnt;
                        w_match_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (r_cnt != r_ref) begin
                        w_state_nxt = ST_SEARCH;
                        w_match_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_SEARCH;
                    w_match_nxt = '0;
                end
            endcase
        end
    end

    // r_cnt counts edges since the last event; it equals the period at the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_period <= '0;
        end else begin
            if (w_hev)
                r_cnt <= PERIOD_W'(1);
            else if (!w_sat)
                r_cnt <= r_cnt + PERIOD_W'(1);
            if (r_state != ST_SEARCH) begin
                if (w_sat)
                    r_period <= '1;
                else if (w_hev)
                    r_period <= r_cnt;
            end
        end
    end

    logic [LINES_W-1:0] r_lines;
    logic [LINES_W-1:0] r_lpf;
    logic [LINES_W-1:0] w_lines_inc;
    logic               r_vseen;
    logic [FRAME_W-1:0] r_frames;

    assign w_lines_inc = (&r_lines) ? r_lines
                                    : r_lines + LINES_W'(w_hev);

    // A coincident HSYNC event is counted into the captured frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lines  <= '0;
            r_lpf    <= '0;
            r_vseen  <= 1'b0;
            r_frames <= '0;
        end else begin
            if (w_vev) begin
                if (r_vseen)
                    r_lpf <= w_lines_inc;
                r_vseen <= 1'b1;
                r_lines <= '0;
            end else begin
                r_lines <= w_lines_inc;
            end
            if (w_vev && w_locked)
                r_frames <= r_frames + FRAME_W'(1);
        end
    end

    logic [7:0] w_crc;
    logic       w_unused;

`ifdef VGA_RX_CRC_EN
    logic [7:0] r_crc_acc;
    logic [7:0] r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc_acc <= '0;
            r_crc     <= '0;
        end else if (w_vev) begin
            r_crc     <= r_crc_acc;
            r_crc_acc <= '0;
        end else if (w_locked && h_ev.s && v_ev.s) begin
            r_crc_acc <= crc8_step6(r_crc_acc, r_col);
        end
    end

    assign w_crc    = r_crc;
    assign w_unused = ^{ena, uio_in[7:3]};
`else
    assign w_crc    = 8'h00;
    assign w_unused = ^{ena, uio_in[7:3],
                        r_col[4], r_col[2], r_col[0]};
`endif

    sel_e w_sel;
    assign w_sel = sel_e'(uio_in[2:0]);

    always_comb begin
        uo_out = 8'h00;
        unique case (w_sel)
            SEL_STATUS: uo_out = {w_locked, r_state, v_ev.s, h_ev.s,
                                  r_col[5], r_col[3], r_col[1]};
            SEL_PER_LO: uo_out = r_period[7:0];
            SEL_PER_HI: uo_out = {6'b0, r_period[9:8]};
            SEL_LPF_LO: uo_out = r_lpf[7:0];
            SEL_LPF_HI: uo_out = {6'b0, r_lpf[9:8]};
            SEL_FRAMES: uo_out = r_frames;
            SEL_CRC:    uo_out = w_crc;
            SEL_ZERO:   uo_out = 8'h00;
            default:    uo_out = 8'h00;
        endcase
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_vga_rx.sv
// Directed bench for tt_um_vga_rx: lock, unlock, saturation,
// reset, frame count wrap and frame CRC.
module tb_tt_um_vga_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena = 1'b1;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_chk;
    int n_pass;

    tt_um_vga_rx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%02h want 0x%02h", tag, obs, exp);
    endtask

    task automatic chk_sel(input string tag, input logic [2:0] sel,
                           input logic [7:0] exp);
        uio_in = {5'b0, sel};
        #1;
        chk(tag, uo_out, exp);
    endtask

    task automatic tick(input bit h, input bit v, input bit r1);
        @(negedge clk);
        ui_in = {h, 3'b000, v, 2'b00, r1};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0);
    endtask

    task automatic drive_line(input int len, input int hlow,
                              input int from, input bit v,
                              input bit r1);
        for (int c = from; c < len; c++) tick(c >= hlow, v, r1);
    endtask

    task automatic drive_frames(input int nf, input int len,
                                input int hlow, input int nl,
                                input int vl, input bit r1);
        for (int f = 0; f < nf; f++)
            for (int l = 0; l < nl; l++)
                drive_line(len, hlow, 0, l >= vl, r1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ui_in = 8'h88;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(4);
    endtask

    function automatic logic [7:0] ref_crc(input int n,
                                           input logic [5:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int k = 0; k < n; k++)
            for (int i = 5; i >= 0; i--) begin
                fb = c[7] ^ d[i];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        return c;
    endfunction

    logic [7:0] exp_crc;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
`ifdef VGA_RX_CRC_EN
        exp_crc = ref_crc(72, 6'b100000);
`else
        exp_crc = 8'h00;
`endif

        // reset with inputs low
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 8; s++)
            chk_sel($sformatf("rst_sel%0d", s), 3'(s), 8'h00);
        chk("uio_out", uio_out, 8'h00);
        chk("uio_oe", uio_oe, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // 800-clock lines: MEASURE after 4 falls, LOCKED after 5
        for (int i = 0; i < 4; i++) drive_line(800, 96, 0, 1'b1, 1'b0);
        chk_sel("measure4", 3'd0, 8'h38);
        drive_line(800, 96, 0, 1'b1, 1'b0);
        chk_sel("lock_status", 3'd0, 8'hD8);
        chk_sel("per_lo_800", 3'd1, 8'h20);
        chk_sel("per_hi_800", 3'd2, 8'h03);

        // periods 800,800,800 then 801
        for (int i = 0; i < 3; i++) drive_line(800, 96, 0, 1'b1, 1'b0);
        drive_line(801, 96, 0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_sel("801_pre", 3'd0, 8'hD0);
        @(posedge clk);
        #1;
        chk_sel("801_search", 3'd0, 8'h10);
        chk_sel("per_lo_801", 3'd1, 8'h21);
        chk_sel("per_hi_801", 3'd2, 8'h03);
        drive_line(800, 96, 4, 1'b1, 1'b0);

        // relock, then hold HSYNC high past saturation
        for (int i = 0; i < 6; i++) drive_line(800, 96, 0, 1'b1, 1'b0);
        chk_sel("relock", 3'd0, 8'hD8);
        drive_line(1196, 96, 0, 1'b1, 1'b0);
        chk_sel("sat_status", 3'd0, 8'h18);
        chk_sel("sat_per_lo", 3'd1, 8'hFF);
        chk_sel("sat_per_hi", 3'd2, 8'h03);

        // asynchronous reset mid-line
        for (int i = 0; i < 6; i++) drive_line(800, 96, 0, 1'b1, 1'b0);
        chk_sel("pre_rst_lock", 3'd0, 8'hD8);
        drive_line(300, 96, 0, 1'b1, 1'b0);
        #5;
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 8; s++)
            chk_sel($sformatf("async_sel%0d", s), 3'(s), 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        for (int i = 0; i < 4; i++) drive_line(800, 96, 0, 1'b1, 1'b0);
        chk_sel("post_rst_meas", 3'd0, 8'h38);
        drive_line(800, 96, 0, 1'b1, 1'b0);
        chk_sel("post_rst_lock", 3'd0, 8'hD8);

        // 525-line frames of 10-clock lines
        do_reset();
        drive_frames(2, 10, 2, 525, 3, 1'b0);
        chk_sel("lpf_lo_525", 3'd3, 8'h0D);
        chk_sel("lpf_hi_525", 3'd4, 8'h02);
        chk_sel("per_lo_10", 3'd1, 8'h0A);

        // frame counter wrap over 257 locked frames
        do_reset();
        drive_frames(257, 10, 2, 10, 1, 1'b0);
        chk_sel("frames_256", 3'd5, 8'h00);
        drive_frames(1, 10, 2, 10, 1, 1'b0);
        chk_sel("frames_257", 3'd5, 8'h01);
        chk_sel("lpf_lo_10", 3'd3, 8'h0A);
        chk_sel("lpf_hi_10", 3'd4, 8'h00);
        chk_sel("wrap_status", 3'd0, 8'hD8);

        // frame CRC: black, then R1-only frames
        drive_frames(2, 10, 2, 10, 1, 1'b0);
        chk_sel("crc_black", 3'd6, 8'h00);
        drive_frames(3, 10, 2, 10, 1, 1'b1);
        chk_sel("crc_r1_a", 3'd6, exp_crc);
        drive_frames(1, 10, 2, 10, 1, 1'b1);
        chk_sel("crc_r1_b", 3'd6, exp_crc);
        chk_sel("sel7_zero", 3'd7, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
